// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding, FSM states and
// counter sizing helper.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_e;

  // Bits needed to hold an iteration count of n (counter loads n and counts down to 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational core: STEPS_PER_CYCLE chained shift-add (multiply) or restoring-subtract
// (divide) iterations on the {hi, lo} accumulator pair.
module muldiv_step #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_s [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] lo_s [STEPS_PER_CYCLE+1];

  assign hi_s[0] = hi_i;
  assign lo_s[0] = lo_i;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply: conditionally add multiplicand into hi, then shift {carry, hi, lo} right.
    assign sum  = {1'b0, hi_s[i]} + (lo_s[i][0] ? {1'b0, b_i} : '0);
    // Divide: shift next dividend bit into the remainder; the difference fits WIDTH bits
    // whenever it is kept, since the remainder always stays below the divisor.
    assign sh   = {hi_s[i], lo_s[i][WIDTH-1]};
    assign ge   = sh >= {1'b0, b_i};
    assign diff = sh[WIDTH-1:0] - b_i;

    assign hi_s[i+1] = is_div_i ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
    assign lo_s[i+1] = is_div_i ? {lo_s[i][WIDTH-2:0], ge} : {sum[0], lo_s[i][WIDTH-1:1]};
  end

  assign hi_o = hi_s[STEPS_PER_CYCLE];
  assign lo_o = lo_s[STEPS_PER_CYCLE];

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO register pair; works on operand
// magnitudes and applies sign correction in a final FIX cycle.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             flush_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] mtdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned N    = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CntW = cnt_width(N);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               signed_op, a_neg, b_neg, abort;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_step #(
    .WIDTH           (WIDTH),
    .STEPS_PER_CYCLE (STEPS_PER_CYCLE)
  ) u_step (
    .is_div_i (is_div_q),
    .b_i      (b_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & srca_i[WIDTH-1];
  assign b_neg     = signed_op & srcb_i[WIDTH-1];
  assign abort     = flush_i | mthi_i | mtlo_i;

  // Sign flags are only ever set for signed ops, so unsigned results pass through untouched.
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
  assign quo_fix  = b_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = MD_RUN;
          cnt_d    = CntW'(N);
          is_div_d = op_i[1];
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          b_zero_d = (srcb_i == '0);
          acc_hi_d = '0;
          acc_lo_d = a_neg ? -srca_i : srca_i;
          b_d      = b_neg ? -srcb_i : srcb_i;
        end
      end
      MD_RUN: begin
        if (abort) begin
          state_d = MD_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
            dz_d = b_zero_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase

    if (mthi_i) hi_d = mtdata_i;
    if (mtlo_i) lo_d = mtdata_i;

    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: WIDTH=32 with one and four iterations per cycle.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] srca, srcb, mtdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        s4_start;
  logic [1:0]  s4_op;
  logic [31:0] s4_srca, s4_srcb;
  logic        s4_busy, s4_done, s4_dz;
  logic [31:0] s4_hi, s4_lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_hilo_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .op_i       (op),
    .srca_i     (srca),
    .srcb_i     (srcb),
    .flush_i    (flush),
    .mthi_i     (mthi),
    .mtlo_i     (mtlo),
    .mtdata_i   (mtdata),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  muldiv_hilo_unit #(.WIDTH(32), .STEPS_PER_CYCLE(4)) u_dut4 (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (s4_start),
    .op_i       (s4_op),
    .srca_i     (s4_srca),
    .srcb_i     (s4_srcb),
    .flush_i    (1'b0),
    .mthi_i     (1'b0),
    .mtlo_i     (1'b0),
    .mtdata_i   (32'h0),
    .busy_o     (s4_busy),
    .done_o     (s4_done),
    .div_zero_o (s4_dz),
    .hi_o       (s4_hi),
    .lo_o       (s4_lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The hazard unit must never issue a new operation while one is in flight.
  always @(negedge clk) begin
    if (busy && start) check_eq("start_while_busy", 64'(start), 64'd0);
  end

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz);
    int   cyc;
    logic early;
    op = o; srca = a; srcb = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; early = 1'b0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) early = 1'b1;
      tick();
    end
    check_eq({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
    check_eq({tag, "_early_done"}, 64'(early), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   cyc;
    logic saw_done;

    reset = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = MD_MULT; srca = '0; srcb = '0; mtdata = '0;
    s4_start = 1'b0; s4_op = MD_MULTU; s4_srca = '0; s4_srcb = '0;
    #22;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_dz", 64'(div_zero), 64'd0);
    check_eq("reset_hi", 64'(hi), 64'd0);
    check_eq("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", MD_DIVU, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_op("div_zero_neg", MD_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // Preload HI/LO, then abort a MULT with flush in its 10th busy cycle.
    mthi = 1'b1; mtdata = 32'hA; tick(); mthi = 1'b0;
    mtlo = 1'b1; mtdata = 32'hB; tick(); mtlo = 1'b0;
    check_eq("mt_hi", 64'(hi), 64'hA);
    check_eq("mt_lo", 64'(lo), 64'hB);
    op = MD_MULT; srca = 32'd5; srcb = 32'd6; start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    check_eq("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_hi", 64'(hi), 64'hA);
    check_eq("flush_lo", 64'(lo), 64'hB);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check_eq("flush_no_done", 64'(saw_done), 64'd0);

    // Same again, aborting via MTLO instead.
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    mtlo = 1'b1; mtdata = 32'hC; tick(); mtlo = 1'b0;
    check_eq("mtlo_abort_busy", 64'(busy), 64'd0);
    check_eq("mtlo_abort_hi", 64'(hi), 64'hA);
    check_eq("mtlo_abort_lo", 64'(lo), 64'hC);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check_eq("mtlo_abort_no_done", 64'(saw_done), 64'd0);

    // Flush in the same IDLE cycle as start drops the start.
    start = 1'b1; flush = 1'b1; tick(); start = 1'b0; flush = 1'b0;
    check_eq("flush_start_busy", 64'(busy), 64'd0);

    // MTHI with start in IDLE: write lands now, result overwrites later.
    op = MD_MULTU; srca = 32'd3; srcb = 32'd4; start = 1'b1; mthi = 1'b1; mtdata = 32'h55;
    tick();
    start = 1'b0; mthi = 1'b0;
    check_eq("mthi_start_hi", 64'(hi), 64'h55);
    check_eq("mthi_start_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 200) begin cyc++; tick(); end
    check_eq("mthi_start_done", 64'(done), 64'd1);
    check_eq("mthi_start_res_hi", 64'(hi), 64'h0);
    check_eq("mthi_start_res_lo", 64'(lo), 64'd12);
    tick();

    // Asynchronous reset mid-RUN takes effect without a clock edge.
    op = MD_MULTU; srca = 32'hFFFF; srcb = 32'hFFFF; start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check_eq("areset_pre_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_busy", 64'(busy), 64'd0);
    check_eq("areset_hi", 64'(hi), 64'd0);
    check_eq("areset_lo", 64'(lo), 64'd0);
    #2 reset = 1'b0;
    tick();
    check_eq("areset_idle", 64'(busy), 64'd0);

    // Four iterations per cycle: N = 8, busy for 9 cycles.
    s4_op = MD_MULTU; s4_srca = 32'h0001_0000; s4_srcb = 32'h0001_0000; s4_start = 1'b1;
    tick();
    s4_start = 1'b0;
    cyc = 0;
    while (s4_busy && cyc < 100) begin cyc++; tick(); end
    check_eq("s4_busy_cycles", 64'(cyc), 64'd9);
    check_eq("s4_done", 64'(s4_done), 64'd1);
    check_eq("s4_hi", 64'(s4_hi), 64'd1);
    check_eq("s4_lo", 64'(s4_lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide engine that owns the architectural HI/LO register pair for the pipelined core.
- Replaces the single-cycle hilo result path. Accepts MULT/MULTU/DIV/DIVU from the execute stage and raises busy so the hazard unit stalls MFHI/MFLO and any new mul/div.
- Generalised in operand width and in iterations per cycle.
- Supports flush/abort and direct MTHI/MTLO writes.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- STEPS_PER_CYCLE, 1: shift-add or restoring-divide iterations per clock; legal values are 1, 2, 4, and it must divide WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  launch operation (execute stage, not stalled)
- op  in  2  operation code, see package
- srca  in  WIDTH  multiplicand / dividend
- srcb  in  WIDTH  multiplier / divisor
- flush  in  1  abort the in-flight operation
- mthi  in  1  write mtdata to HI
- mtlo  in  1  write mtdata to LO
- mtdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight (registered)
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- div_zero  out  1  one-cycle pulse with done when the divisor was zero
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; busy, done, div_zero = 0; hi, lo = 0; internal accumulators and counter = 0. Reset asserted mid-operation discards the operation.
- Let N = WIDTH/STEPS_PER_CYCLE.
- States:
  - IDLE: start=1 at edge E0 latches op and operands, converts signed operands to magnitudes, loads counter=N, and goes to RUN.
  - RUN: each edge performs STEPS_PER_CYCLE iterations and decrements the counter. When counter reaches 1 at the edge, go to FIX.
  - FIX: one edge applies sign correction and writes HI/LO, pulses done, returns to IDLE.
- Timing:
  - busy=1 for exactly N+1 cycles, i.e. from after E0 through edge E(N+1).
  - HI/LO are new from E(N+1).
  - done=1 in the cycle after E(N+1), coincident with busy=0.
- Multiply:
  - {HI,LO} = full 2*WIDTH-bit product.
  - MULT is signed, MULTU unsigned.
  - The product is negated in FIX if operand signs differ (MULT only).
- Divide:
  - LO = quotient, truncated toward zero; HI = remainder, sign of dividend. DIVU is unsigned.
  - Divisor zero (both DIV and DIVU): LO = all ones, HI = srca unchanged, div_zero=1 with done. Latency is the same (N+1).
  - DIV of most-negative value by -1: LO = most-negative, HI = 0, no flag.
- Simultaneous and boundary events:
  - start while busy: ignored. The hazard unit guarantees this never happens; bench asserts it.
  - flush while busy: abort next edge, state=IDLE, busy=0 next cycle, HI/LO unchanged, no done.
  - flush and start in the same IDLE cycle: start is dropped.
  - mthi/mtlo while IDLE: register written at the edge.
  - mthi/mtlo while busy: the operation is aborted (as flush), then the write is applied.
  - mthi/mtlo together with start in IDLE: the write is applied and start is accepted; the later result overwrites.
  - Writes to HI/LO happen only at a FIX edge or an mthi/mtlo edge.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
  - state typedef: MD_IDLE, MD_RUN, MD_FIX
  - helper constant for counter width: clog2(N+1)
- One natural sub-module: muldiv_step. It is combinational and performs STEPS_PER_CYCLE chained shift-add/restoring-subtract iterations. It is instantiated once; the top module holds the FSM, counter, sign fix-up and HI/LO.

Test Plan (WIDTH=32 unless stated):
- MULT srca=0xFFFFFFFD, srcb=7 -> busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done one cycle.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Divide results:
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 -> LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678, div_zero and done pulse together after 33 busy cycles.
- Abort and reset:
  - Preload HI=0xA, LO=0xB via mthi/mtlo; start MULT; assert flush in the 10th busy cycle -> busy=0 next cycle, HI=0xA, LO=0xB, no done.
  - Repeat with mtlo=0xC instead of flush -> LO=0xC, HI=0xA.
  - Async reset mid-RUN -> hi=lo=0, busy=0 immediately.
- STEPS_PER_CYCLE=4: MULTU 0x00010000*0x00010000 -> busy 9 cycles, HI=1, LO=0.
